// File: rtl/gc_pkg.sv
// Shared constants for the garbled-circuit gate engine: gate types, sticky error codes, FSM states.
package gc_pkg;

  localparam logic [1:0] GT_AND  = 2'd0;
  localparam logic [1:0] GT_XOR  = 2'd1;
  localparam logic [1:0] GT_BUF  = 2'd2;
  localparam logic [1:0] GT_RSVD = 2'd3;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_BUSY      = 3'd1;
  localparam logic [2:0] ERR_CTXT_TYPE = 3'd2;
  localparam logic [2:0] ERR_CTXT_IDX0 = 3'd3;
  localparam logic [2:0] ERR_CTXT_DUP  = 3'd4;
  localparam logic [2:0] ERR_GATE_TYPE = 3'd5;
  localparam logic [2:0] ERR_OUT_DUP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HASH,
    S_CTXT,
    S_OUTID,
    S_WRITE
  } state_e;

endpackage

// File: rtl/gc_ctxt_buf.sv
// Ciphertext row store with valid bits; rows written once per gate, duplicates flagged and ignored.
// Entry 0 is never written (row 0 is implicit), so its valid bit stays clear.
module gc_ctxt_buf #(
  parameter int LABEL_W  = 128,
  parameter int NUM_CTXT = 4,
  parameter int PTR_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [PTR_W-1:0]   wr_idx_i,
  input  logic [LABEL_W-1:0] wr_dat_i,
  input  logic [PTR_W-1:0]   rd_idx_i,
  output logic               rd_vld_o,
  output logic [LABEL_W-1:0] rd_dat_o,
  output logic               dup_o
);
  import gc_pkg::*;

  logic [NUM_CTXT-1:0] vld_q, vld_d;
  logic [LABEL_W-1:0]  mem_q [NUM_CTXT];
  logic                wr_ok;

  // A write in the clearing cycle belongs to the next gate, so it is never a duplicate.
  assign dup_o    = wr_en_i && vld_q[wr_idx_i] && !clr_i;
  assign wr_ok    = wr_en_i && !dup_o;
  assign rd_vld_o = vld_q[rd_idx_i];
  assign rd_dat_o = mem_q[rd_idx_i];

  always_comb begin
    vld_d = clr_i ? '0 : vld_q;
    if (wr_ok) vld_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_idx_i] <= wr_dat_i;
  end

endmodule

// File: rtl/gc_gate_engine.sv
// Garbled-circuit gate evaluator: label fetch, AES hash for AND, ciphertext select, held write request.
// Result reaches wr_req one cycle after rd_done/aes_done when operands are pending; GC_STATS_EN adds gate counters.
module gc_gate_engine #(
  parameter int LABEL_W  = 128,
  parameter int ID_W     = 13,
  parameter int NUM_CTXT = 4,
  parameter int PTR_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         gate_type,
  input  logic               gate_strobe,
  input  logic               id_1_strobe,
  input  logic               id_2_strobe,
  input  logic [ID_W-1:0]    in_id,
  input  logic               ctxt_strobe,
  input  logic [PTR_W-1:0]   ctxt_idx,
  input  logic [LABEL_W-1:0] ctxt,
  input  logic               out_strobe,
  input  logic [ID_W-1:0]    out_id,
  output logic               rd_req,
  output logic [ID_W-1:0]    rd_id,
  input  logic               rd_done,
  input  logic [LABEL_W-1:0] rd_label,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic               aes_start,
  output logic [LABEL_W-1:0] aes_in,
  input  logic               aes_done,
  input  logic [LABEL_W-1:0] aes_out,
  output logic               wr_req,
  output logic [ID_W-1:0]    wr_id,
  output logic [LABEL_W-1:0] wr_label,
  input  logic               wr_ack,
  output logic               busy,
  output logic [2:0]         err_code,
  input  logic               err_clr
`ifdef GC_STATS_EN
  ,
  output logic [31:0]        and_cnt,
  output logic [31:0]        xor_cnt,
  output logic [31:0]        buf_cnt
`endif
);
  import gc_pkg::*;

  state_e             state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic               hdr_vld_q, hdr_vld_d;
  logic               rd_req_q, rd_req_d;
  logic [ID_W-1:0]    rd_id_q, rd_id_d;
  logic               aes_start_q, aes_start_d;
  logic [LABEL_W-1:0] aes_in_q, aes_in_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [LABEL_W-1:0] result_q, result_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic               out_pend_q, out_pend_d;
  logic               wr_req_q, wr_req_d;
  logic [2:0]         err_q, err_d, new_err;
  logic               fin, e_busy, e_rsvd, e_idx0, e_type, e_out_dup;
  logic               hdr_ok, is_and, have_out, ctxt_hit, gate_done, buf_wr, buf_vld, buf_dup;
  logic [LABEL_W-1:0] buf_dat;

  assign gate_done = (state_q == S_WRITE) && wr_ack;
  assign hdr_ok    = (state_q == S_IDLE) || gate_done;
  // Ciphertexts seen before any header are assumed to belong to an upcoming AND gate.
  assign is_and    = !hdr_vld_q || (type_q == GT_AND);
  assign buf_wr    = ctxt_strobe && (ctxt_idx != '0) && is_and;
  assign have_out  = out_pend_q || out_strobe;
  assign ctxt_hit  = ctxt_strobe && (ctxt_idx == ptr_q);

  gc_ctxt_buf #(.LABEL_W(LABEL_W), .NUM_CTXT(NUM_CTXT), .PTR_W(PTR_W)) u_ctxt_buf (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (gate_done),
    .wr_en_i  (buf_wr),
    .wr_idx_i (ctxt_idx),
    .wr_dat_i (ctxt),
    .rd_idx_i (ptr_q),
    .rd_vld_o (buf_vld),
    .rd_dat_o (buf_dat),
    .dup_o    (buf_dup)
  );

  always_comb begin
    state_d = state_q;   type_d = type_q;     hdr_vld_d = hdr_vld_q;
    rd_req_d = 1'b0;     rd_id_d = rd_id_q;   aes_start_d = 1'b0;
    aes_in_d = aes_in_q; ptr_d = ptr_q;       result_d = result_q;
    out_id_d = out_id_q; out_pend_d = out_pend_q;
    wr_req_d = wr_req_q; err_d = err_q;       new_err = ERR_NONE;
    fin = 1'b0; e_busy = 1'b0; e_rsvd = 1'b0; e_idx0 = 1'b0; e_type = 1'b0; e_out_dup = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (id_1_strobe || id_2_strobe) rd_id_d = in_id;
        if (hdr_vld_q && ((id_2_strobe && type_q != GT_BUF) || (id_1_strobe && type_q == GT_BUF))) begin
          rd_req_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: if (rd_done) begin
        ptr_d = rd_ptr;
        if (type_q == GT_AND) begin
          aes_in_d    = rd_label;
          aes_start_d = 1'b1;
          state_d     = S_HASH;
        end else begin
          result_d = rd_label;
          fin      = 1'b1;
        end
      end
      S_HASH: if (aes_done) begin
        fin = 1'b1;
        if (ptr_q == '0)   result_d = aes_out;
        else if (buf_vld)  result_d = aes_out ^ buf_dat;
        else if (ctxt_hit) result_d = aes_out ^ ctxt;
        else begin
          // Park the hash in result_q; the late ciphertext is folded in from CTXT.
          result_d = aes_out;
          fin      = 1'b0;
          state_d  = S_CTXT;
        end
      end
      S_CTXT: if (ctxt_hit) begin
        result_d = result_q ^ ctxt;
        fin      = 1'b1;
      end
      S_OUTID: if (have_out) begin
        wr_req_d = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: if (wr_ack) begin
        wr_req_d   = 1'b0;
        hdr_vld_d  = 1'b0;
        out_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      if (have_out) begin
        wr_req_d = 1'b1;
        state_d  = S_WRITE;
      end else begin
        state_d = S_OUTID;
      end
    end

    if (gate_strobe) begin
      if (!hdr_ok) e_busy = 1'b1;
      else if (gate_type == GT_RSVD) begin
        e_rsvd    = 1'b1;
        hdr_vld_d = 1'b0;
      end else begin
        type_d    = gate_type;
        hdr_vld_d = 1'b1;
      end
    end
    if ((id_1_strobe || id_2_strobe) && state_q != S_IDLE) e_busy = 1'b1;

    if (ctxt_strobe) begin
      if (ctxt_idx == '0) e_idx0 = 1'b1;
      else if (!is_and)   e_type = 1'b1;
    end

    if (out_strobe) begin
      if (out_pend_q && !gate_done) e_out_dup = 1'b1;
      else begin
        out_id_d   = out_id;
        out_pend_d = 1'b1;
      end
    end

    if (e_busy)         new_err = ERR_BUSY;
    else if (e_rsvd)    new_err = ERR_GATE_TYPE;
    else if (e_idx0)    new_err = ERR_CTXT_IDX0;
    else if (e_type)    new_err = ERR_CTXT_TYPE;
    else if (buf_dup)   new_err = ERR_CTXT_DUP;
    else if (e_out_dup) new_err = ERR_OUT_DUP;

    if (err_clr)                err_d = ERR_NONE;
    else if (err_q == ERR_NONE) err_d = new_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  type_q <= GT_AND;   hdr_vld_q <= 1'b0;
      rd_req_q <= 1'b0;   rd_id_q <= '0;      aes_start_q <= 1'b0;
      aes_in_q <= '0;     ptr_q <= '0;        result_q <= '0;
      out_id_q <= '0;     out_pend_q <= 1'b0; wr_req_q <= 1'b0;
      err_q <= ERR_NONE;
    end else begin
      state_q <= state_d;   type_q <= type_d;         hdr_vld_q <= hdr_vld_d;
      rd_req_q <= rd_req_d; rd_id_q <= rd_id_d;       aes_start_q <= aes_start_d;
      aes_in_q <= aes_in_d; ptr_q <= ptr_d;           result_q <= result_d;
      out_id_q <= out_id_d; out_pend_q <= out_pend_d; wr_req_q <= wr_req_d;
      err_q <= err_d;
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_id     = rd_id_q;
  assign aes_start = aes_start_q;
  assign aes_in    = aes_in_q;
  assign wr_req    = wr_req_q;
  assign wr_id     = out_id_q;
  assign wr_label  = result_q;
  assign busy      = (state_q != S_IDLE);
  assign err_code  = err_q;

`ifdef GC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      and_cnt <= '0;
      xor_cnt <= '0;
      buf_cnt <= '0;
    end else if (gate_done) begin
      case (type_q)
        GT_AND:  and_cnt <= and_cnt + 32'd1;
        GT_XOR:  xor_cnt <= xor_cnt + 32'd1;
        GT_BUF:  buf_cnt <= buf_cnt + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gc_gate_engine.sv
// Directed bench for gc_gate_engine: XOR/BUF/AND paths, ciphertext buffering, errors, reset, back-to-back.
module tb_gc_gate_engine;
  localparam int LABEL_W = 128, ID_W = 13, NUM_CTXT = 4, PTR_W = 2;

  logic               clk = 1'b0, rst;
  logic [1:0]         gate_type;
  logic               gate_strobe, id_1_strobe, id_2_strobe;
  logic [ID_W-1:0]    in_id, out_id, rd_id, wr_id;
  logic               ctxt_strobe, out_strobe, rd_req, rd_done, aes_start, aes_done;
  logic [PTR_W-1:0]   ctxt_idx, rd_ptr;
  logic [LABEL_W-1:0] ctxt, rd_label, aes_in, aes_out, wr_label;
  logic               wr_req, wr_ack, busy, err_clr;
  logic [2:0]         err_code;

  int n_tests = 0, n_fail = 0;
  localparam logic [LABEL_W-1:0] LBL_AA = {16{8'hAA}};

  always #5 clk = ~clk;

  gc_gate_engine #(.LABEL_W(LABEL_W), .ID_W(ID_W), .NUM_CTXT(NUM_CTXT), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .gate_type(gate_type), .gate_strobe(gate_strobe),
    .id_1_strobe(id_1_strobe), .id_2_strobe(id_2_strobe), .in_id(in_id),
    .ctxt_strobe(ctxt_strobe), .ctxt_idx(ctxt_idx), .ctxt(ctxt),
    .out_strobe(out_strobe), .out_id(out_id), .rd_req(rd_req), .rd_id(rd_id),
    .rd_done(rd_done), .rd_label(rd_label), .rd_ptr(rd_ptr),
    .aes_start(aes_start), .aes_in(aes_in), .aes_done(aes_done), .aes_out(aes_out),
    .wr_req(wr_req), .wr_id(wr_id), .wr_label(wr_label), .wr_ack(wr_ack),
    .busy(busy), .err_code(err_code), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_gate(input logic [1:0] t, input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
    gate_type = t; gate_strobe = 1'b1; tick(); gate_strobe = 1'b0;
    in_id = a; id_1_strobe = 1'b1; tick(); id_1_strobe = 1'b0;
    if (t != 2'd2) begin in_id = b; id_2_strobe = 1'b1; tick(); id_2_strobe = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b1; gate_type = '0; gate_strobe = 0; id_1_strobe = 0; id_2_strobe = 0; in_id = '0;
    ctxt_strobe = 0; ctxt_idx = '0; ctxt = '0; out_strobe = 0; out_id = '0; rd_done = 0;
    rd_label = '0; rd_ptr = '0; aes_done = 0; aes_out = '0; wr_ack = 0; err_clr = 0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if ({rd_req, aes_start, wr_req} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b want 000", {rd_req, aes_start, wr_req}); end
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_code); end
    n_tests++; if (wr_label !== '0 || aes_in !== '0 || wr_id !== '0 || rd_id !== '0) begin n_fail++; $display("FAIL rst_data: wr_label %h aes_in %h wr_id %0d rd_id %0d want all 0", wr_label, aes_in, wr_id, rd_id); end
    rst = 1'b0; tick();
  endtask

  task automatic test_xor();
    start_gate(2'd1, 13'd5, 13'd9);
    n_tests++; if (rd_req !== 1'b1 || rd_id !== 13'd9) begin n_fail++; $display("FAIL xor_rd_req: got req %b id %0d want 1 9", rd_req, rd_id); end
    out_strobe = 1; out_id = 13'd20; tick(); out_strobe = 0;
    n_tests++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL xor_rd_pulse: got %b want 0", rd_req); end
    rd_done = 1; rd_label = LBL_AA; tick(); rd_done = 0;
    n_tests++; if (wr_req !== 1'b1 || wr_id !== 13'd20 || wr_label !== LBL_AA) begin n_fail++; $display("FAIL xor_write: got req %b id %0d label %h want 1 20 %h", wr_req, wr_id, wr_label, LBL_AA); end
    wr_ack = 1; tick(); wr_ack = 0;
    n_tests++; if (wr_req !== 1'b0 || busy !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL xor_done: got req %b busy %b err %0d want 0 0 0", wr_req, busy, err_code); end
  endtask

  task automatic test_and_ptr0();
    start_gate(2'd0, 13'd3, 13'd4);
    out_strobe = 1; out_id = 13'd7; tick(); out_strobe = 0;
    rd_done = 1; rd_label = 128'h55; rd_ptr = 2'd0; tick(); rd_done = 0;
    n_tests++; if (aes_start !== 1'b1 || aes_in !== 128'h55) begin n_fail++; $display("FAIL and0_aes_start: got %b in %h want 1 55", aes_start, aes_in); end
    tick();
    n_tests++; if (aes_start !== 1'b0) begin n_fail++; $display("FAIL and0_aes_pulse: got %b want 0", aes_start); end
    aes_done = 1; aes_out = 128'h1234; tick(); aes_done = 0; aes_out = '0;
    n_tests++; if (wr_req !== 1'b1 || wr_label !== 128'h1234 || wr_id !== 13'd7) begin n_fail++; $display("FAIL and0_write: got req %b label %h id %0d want 1 1234 7", wr_req, wr_label, wr_id); end
    wr_ack = 1; tick(); wr_ack = 0;
  endtask

  task automatic test_and_buffered();
    start_gate(2'd0, 13'd1, 13'd2);
    ctxt_strobe = 1; ctxt_idx = 2'd1; ctxt = 128'h11; tick();
    ctxt_idx = 2'd2; ctxt = 128'hFF; tick();
    ctxt_idx = 2'd3; ctxt = 128'h33; out_strobe = 1; out_id = 13'd21; tick();
    ctxt_strobe = 0; out_strobe = 0;
    rd_done = 1; rd_label = 128'h9; rd_ptr = 2'd2; tick(); rd_done = 0;
    tick();
    aes_done = 1; aes_out = 128'h0F; tick(); aes_done = 0; aes_out = '0;
    n_tests++; if (wr_req !== 1'b1 || wr_label !== 128'hF0 || wr_id !== 13'd21) begin n_fail++; $display("FAIL andbuf_write: got req %b label %h id %0d want 1 f0 21", wr_req, wr_label, wr_id); end
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL andbuf_err: got %0d want 0", err_code); end
    wr_ack = 1; tick(); wr_ack = 0;
  endtask

  task automatic test_and_late_ctxt();
    start_gate(2'd0, 13'd6, 13'd7);
    rd_done = 1; rd_label = 128'h1; rd_ptr = 2'd3; tick(); rd_done = 0;
    aes_done = 1; aes_out = 128'hABCD; tick(); aes_done = 0; aes_out = '0;
    repeat (10) tick();
    n_tests++; if (busy !== 1'b1 || wr_req !== 1'b0) begin n_fail++; $display("FAIL late_wait: got busy %b req %b want 1 0", busy, wr_req); end
    ctxt_strobe = 1; ctxt_idx = 2'd3; ctxt = 128'h1111; tick(); ctxt_strobe = 0;
    n_tests++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL late_outid_wait: got %b want 0", wr_req); end
    out_strobe = 1; out_id = 13'd30; tick(); out_strobe = 0;
    n_tests++; if (wr_req !== 1'b1 || wr_label !== 128'hBADC || wr_id !== 13'd30) begin n_fail++; $display("FAIL late_write: got req %b label %h id %0d want 1 badc 30", wr_req, wr_label, wr_id); end
    wr_ack = 1; tick(); wr_ack = 0;
  endtask

  task automatic test_errors();
    ctxt_strobe = 1; ctxt_idx = 2'd0; tick();
    n_tests++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL err_idx0: got %0d want 3", err_code); end
    ctxt_idx = 2'd1; ctxt = 128'h1; tick(); tick(); ctxt_strobe = 0;
    n_tests++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL err_sticky: got %0d want 3", err_code); end
    err_clr = 1; tick(); err_clr = 0;
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL err_clr: got %0d want 0", err_code); end
    ctxt_strobe = 1; ctxt_idx = 2'd1; tick(); ctxt_strobe = 0;
    n_tests++; if (err_code !== 3'd4) begin n_fail++; $display("FAIL err_dup: got %0d want 4", err_code); end
    err_clr = 1; ctxt_strobe = 1; ctxt_idx = 2'd0; tick(); err_clr = 0; ctxt_strobe = 0;
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL err_clr_prio: got %0d want 0", err_code); end
    gate_type = 2'd3; gate_strobe = 1; tick(); gate_strobe = 0;
    n_tests++; if (err_code !== 3'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL err_rsvd: got err %0d busy %b want 5 0", err_code, busy); end
    in_id = 13'd1; id_1_strobe = 1; tick(); id_1_strobe = 0;
    n_tests++; if (rd_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rsvd_dropped: got req %b busy %b want 0 0", rd_req, busy); end
    err_clr = 1; tick(); err_clr = 0;
  endtask

  task automatic test_reset_in_hash();
    start_gate(2'd0, 13'd2, 13'd3);
    rd_done = 1; rd_label = 128'h5; rd_ptr = 2'd1; tick(); rd_done = 0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hash_busy: got %b want 1", busy); end
    rst = 1; tick(); rst = 0;
    n_tests++; if (busy !== 1'b0 || wr_req !== 1'b0 || aes_start !== 1'b0) begin n_fail++; $display("FAIL rst_hash: got busy %b req %b start %b want 0 0 0", busy, wr_req, aes_start); end
    ctxt_strobe = 1; ctxt_idx = 2'd1; ctxt = 128'h2; tick(); ctxt_strobe = 0;
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL rst_buf_empty: got err %0d want 0", err_code); end
    start_gate(2'd2, 13'd11, 13'd0);
    n_tests++; if (rd_req !== 1'b1 || rd_id !== 13'd11) begin n_fail++; $display("FAIL buf_rd_req: got req %b id %0d want 1 11", rd_req, rd_id); end
    out_strobe = 1; out_id = 13'd40; tick(); out_strobe = 0;
    rd_done = 1; rd_label = 128'h77; tick(); rd_done = 0;
    n_tests++; if (wr_req !== 1'b1 || wr_label !== 128'h77 || wr_id !== 13'd40) begin n_fail++; $display("FAIL buf_write: got req %b label %h id %0d want 1 77 40", wr_req, wr_label, wr_id); end
  endtask

  task automatic test_back_to_back();
    wr_ack = 1; gate_type = 2'd1; gate_strobe = 1; tick(); wr_ack = 0; gate_strobe = 0;
    n_tests++; if (busy !== 1'b0 || wr_req !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL b2b_accept: got busy %b req %b err %0d want 0 0 0", busy, wr_req, err_code); end
    in_id = 13'd12; id_1_strobe = 1; tick(); id_1_strobe = 0;
    in_id = 13'd13; id_2_strobe = 1; tick(); id_2_strobe = 0;
    n_tests++; if (rd_req !== 1'b1 || rd_id !== 13'd13) begin n_fail++; $display("FAIL b2b_rd_req: got req %b id %0d want 1 13", rd_req, rd_id); end
    rd_done = 1; rd_label = 128'h3C; tick(); rd_done = 0;
    n_tests++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL b2b_outid_wait: got %b want 0", wr_req); end
    gate_type = 2'd1; gate_strobe = 1; tick(); gate_strobe = 0;
    n_tests++; if (err_code !== 3'd1) begin n_fail++; $display("FAIL err_busy: got %0d want 1", err_code); end
    err_clr = 1; tick(); err_clr = 0;
    out_strobe = 1; out_id = 13'd50; tick();
    n_tests++; if (wr_req !== 1'b1 || wr_id !== 13'd50 || wr_label !== 128'h3C) begin n_fail++; $display("FAIL b2b_write: got req %b id %0d label %h want 1 50 3c", wr_req, wr_id, wr_label); end
    out_id = 13'd51; tick(); out_strobe = 0;
    n_tests++; if (err_code !== 3'd6 || wr_id !== 13'd50) begin n_fail++; $display("FAIL err_out_dup: got err %0d id %0d want 6 50", err_code, wr_id); end
    wr_ack = 1; tick(); wr_ack = 0;
    n_tests++; if (busy !== 1'b0 || wr_req !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got busy %b req %b want 0 0", busy, wr_req); end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_and_ptr0();
    test_and_buffered();
    test_and_late_ctxt();
    test_errors();
    test_reset_in_hash();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
